// File: rtl/riscv_checkpoint_checker_if.sv
// riscv_checkpoint_checker_if: table-load, core-observation and verdict signals of the checkpoint checker
interface riscv_checkpoint_checker_if #(
    parameter int IDX_W  = 6,
    parameter int DWIDTH = 32
);
    logic              TBL_WE;
    logic [IDX_W-1:0]  TBL_IDX;
    logic [DWIDTH-1:0] TBL_NINST;
    logic [DWIDTH-1:0] TBL_ANS;
    logic [IDX_W:0]    NUM_USED;
    logic              START;
    logic [DWIDTH-1:0] NUM_INST;
    logic [DWIDTH-1:0] OUTPUT_PORT;
    logic              HALT;
    logic              DONE;
    logic              PASS;
    logic [1:0]        FAIL_CODE;
    logic [IDX_W-1:0]  FAIL_IDX;
    logic [DWIDTH-1:0] FAIL_VAL;
    logic [IDX_W:0]    PASS_CNT;
    logic [IDX_W:0]    FAIL_CNT;
    logic [DWIDTH-1:0] CYCLE;

    modport master (
        output TBL_WE, TBL_IDX, TBL_NINST, TBL_ANS, NUM_USED, START, NUM_INST, OUTPUT_PORT, HALT,
        input  DONE, PASS, FAIL_CODE, FAIL_IDX, FAIL_VAL, PASS_CNT, FAIL_CNT, CYCLE
    );
    modport slave (
        input  TBL_WE, TBL_IDX, TBL_NINST, TBL_ANS, NUM_USED, START, NUM_INST, OUTPUT_PORT, HALT,
        output DONE, PASS, FAIL_CODE, FAIL_IDX, FAIL_VAL, PASS_CNT, FAIL_CNT, CYCLE
    );
endinterface

// File: rtl/riscv_checkpoint_checker.sv
// riscv_checkpoint_checker: compares the core's OUTPUT_PORT against a table of (instruction-count, value) checkpoints
module riscv_checkpoint_checker #(
    parameter int NUM_CHK      = 64,
    parameter int IDX_W        = 6,
    parameter int DWIDTH       = 32,
    parameter int TIMEOUT      = 1000000,
    parameter int STOP_ON_FAIL = 1
) (
    input logic                       CLK,
    input logic                       RSTn,
    riscv_checkpoint_checker_if.slave cp_if
);
    typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

    localparam logic [IDX_W:0]    NCHK   = (IDX_W+1)'(NUM_CHK);
    localparam logic [DWIDTH-1:0] TO_M1  = DWIDTH'(TIMEOUT - 1);
    localparam logic [DWIDTH-1:0] ONE    = DWIDTH'(1);

    state_t            state_q, state_d;
    logic [IDX_W:0]    ptr_q, ptr_d, used_q, used_d;
    logic              done_q, done_d, pass_q, pass_d;
    logic [1:0]        code_q, code_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [DWIDTH-1:0] fval_q, fval_d, cyc_q, cyc_d;
    logic [IDX_W:0]    pcnt_q, pcnt_d, fcnt_q, fcnt_d;
    logic [DWIDTH-1:0] ninst_q [NUM_CHK];
    logic [DWIDTH-1:0] ans_q   [NUM_CHK];

    logic              tbl_wr, active, hit, skip, ok, bad;
    logic [DWIDTH-1:0] ninst_cur, ans_cur;
    logic [IDX_W:0]    used_in;

    assign tbl_wr    = RSTn && state_q == IDLE && cp_if.TBL_WE && {1'b0, cp_if.TBL_IDX} < NCHK;
    assign used_in   = cp_if.NUM_USED > NCHK ? NCHK : cp_if.NUM_USED;
    assign active    = state_q == RUN && ptr_q < used_q;
    assign ninst_cur = ninst_q[ptr_q[IDX_W-1:0]];
    assign ans_cur   = ans_q[ptr_q[IDX_W-1:0]];
    assign hit       = active && cp_if.NUM_INST == ninst_cur;
    assign skip      = active && cp_if.NUM_INST > ninst_cur;
    assign ok        = hit && cp_if.OUTPUT_PORT == ans_cur;
    assign bad       = skip || (hit && !ok);

    // The table is deliberately not reset; it is rewritten by the bench before each program.
    always_ff @(posedge CLK) begin
        if (tbl_wr) begin
            ninst_q[cp_if.TBL_IDX] <= cp_if.TBL_NINST;
            ans_q[cp_if.TBL_IDX]   <= cp_if.TBL_ANS;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        used_d  = used_q;
        done_d  = done_q;
        pass_d  = pass_q;
        code_d  = code_q;
        fidx_d  = fidx_q;
        fval_d  = fval_q;
        pcnt_d  = pcnt_q;
        fcnt_d  = fcnt_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE, DONE_ST: begin
                if (cp_if.START) begin
                    state_d = RUN;
                    used_d  = used_in;
                    ptr_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    code_d  = 2'd0;
                    fidx_d  = '0;
                    fval_d  = '0;
                    pcnt_d  = '0;
                    fcnt_d  = '0;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                cyc_d  = &cyc_q ? cyc_q : cyc_q + ONE;
                ptr_d  = ptr_q + (IDX_W+1)'(hit || skip);
                pcnt_d = pcnt_q + (IDX_W+1)'(ok);
                fcnt_d = fcnt_q + (IDX_W+1)'(bad);
                if (bad && code_q == 2'd0) begin
                    code_d = hit ? 2'd1 : 2'd2;
                    fidx_d = ptr_q[IDX_W-1:0];
                    fval_d = cp_if.OUTPUT_PORT;
                end
                // HALT settles this cycle's checkpoint first, then charges every unreached one as missed.
                if (cp_if.HALT) begin
                    if (ptr_d < used_q) begin
                        fcnt_d = fcnt_d + (used_q - ptr_d);
                        if (code_d == 2'd0) begin
                            code_d = 2'd2;
                            fidx_d = ptr_d[IDX_W-1:0];
                            fval_d = cp_if.OUTPUT_PORT;
                        end
                    end
                    state_d = DONE_ST;
                end else if (cyc_q == TO_M1) begin
                    if (code_d == 2'd0) begin
                        code_d = 2'd3;
                        fidx_d = ptr_d[IDX_W-1:0];
                        fval_d = cp_if.OUTPUT_PORT;
                    end
                    state_d = DONE_ST;
                end
                if (STOP_ON_FAIL != 0 && bad) state_d = DONE_ST;
                if (state_d == DONE_ST) begin
                    done_d = 1'b1;
                    pass_d = fcnt_d == '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            used_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            code_q  <= 2'd0;
            fidx_q  <= '0;
            fval_q  <= '0;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            used_q  <= used_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            code_q  <= code_d;
            fidx_q  <= fidx_d;
            fval_q  <= fval_d;
            pcnt_q  <= pcnt_d;
            fcnt_q  <= fcnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign cp_if.DONE      = done_q;
    assign cp_if.PASS      = pass_q;
    assign cp_if.FAIL_CODE = code_q;
    assign cp_if.FAIL_IDX  = fidx_q;
    assign cp_if.FAIL_VAL  = fval_q;
    assign cp_if.PASS_CNT  = pcnt_q;
    assign cp_if.FAIL_CNT  = fcnt_q;
    assign cp_if.CYCLE     = cyc_q;
endmodule

// File: tb/tb_riscv_checkpoint_checker.sv
// tb_riscv_checkpoint_checker: table-driven scoreboard bench for two checker instances (stop-on-fail and keep-going)
module tb_riscv_checkpoint_checker;
    logic        clk = 1'b0;
    logic        rstn;
    logic        tbl_we;
    logic [5:0]  tbl_idx;
    logic [31:0] tbl_ninst, tbl_ans, num_inst, out_port;
    logic [6:0]  num_used;
    logic        start, halt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit sel;
        int used, inc, halt_at, skip_at, bad_at;
        int pass, code, idx, val, pc, fc, cyc;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    riscv_checkpoint_checker_if #(.IDX_W(6), .DWIDTH(32)) if0 ();
    riscv_checkpoint_checker_if #(.IDX_W(6), .DWIDTH(32)) if1 ();

    assign if0.TBL_WE = tbl_we;       assign if1.TBL_WE = tbl_we;
    assign if0.TBL_IDX = tbl_idx;     assign if1.TBL_IDX = tbl_idx;
    assign if0.TBL_NINST = tbl_ninst; assign if1.TBL_NINST = tbl_ninst;
    assign if0.TBL_ANS = tbl_ans;     assign if1.TBL_ANS = tbl_ans;
    assign if0.NUM_USED = num_used;   assign if1.NUM_USED = num_used;
    assign if0.START = start;         assign if1.START = start;
    assign if0.NUM_INST = num_inst;   assign if1.NUM_INST = num_inst;
    assign if0.OUTPUT_PORT = out_port; assign if1.OUTPUT_PORT = out_port;
    assign if0.HALT = halt;           assign if1.HALT = halt;

    riscv_checkpoint_checker #(.NUM_CHK(64), .IDX_W(6), .DWIDTH(32), .TIMEOUT(20), .STOP_ON_FAIL(1)) u0 (
        .CLK(clk), .RSTn(rstn), .cp_if(if0.slave));
    riscv_checkpoint_checker #(.NUM_CHK(64), .IDX_W(6), .DWIDTH(32), .TIMEOUT(20), .STOP_ON_FAIL(0)) u1 (
        .CLK(clk), .RSTn(rstn), .cp_if(if1.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ans_of(input int n, input int bad_at);
        return n == bad_at ? 32'h19 : n == 4 ? 32'h0F00 : n == 6 ? 32'h18 : n == 8 ? 32'h1D : 32'h0;
    endfunction

    task automatic check_outs(input bit sel, input string tag, input vec_t e);
        logic        d, p;
        logic [1:0]  c;
        logic [5:0]  i;
        logic [31:0] v, cy;
        logic [6:0]  pc, fc;
        d  = sel ? if1.DONE : if0.DONE;
        p  = sel ? if1.PASS : if0.PASS;
        c  = sel ? if1.FAIL_CODE : if0.FAIL_CODE;
        i  = sel ? if1.FAIL_IDX : if0.FAIL_IDX;
        v  = sel ? if1.FAIL_VAL : if0.FAIL_VAL;
        pc = sel ? if1.PASS_CNT : if0.PASS_CNT;
        fc = sel ? if1.FAIL_CNT : if0.FAIL_CNT;
        cy = sel ? if1.CYCLE : if0.CYCLE;
        chk({tag, ".done"}, 32'(d), 32'd1);
        chk({tag, ".pass"}, 32'(p), 32'(e.pass));
        chk({tag, ".code"}, 32'(c), 32'(e.code));
        chk({tag, ".idx"}, 32'(i), 32'(e.idx));
        chk({tag, ".val"}, v, 32'(e.val));
        chk({tag, ".pcnt"}, 32'(pc), 32'(e.pc));
        chk({tag, ".fcnt"}, 32'(fc), 32'(e.fc));
        chk({tag, ".cycle"}, cy, 32'(e.cyc));
    endtask

    // One program run: START, then NUM_INST advances by inc per cycle until the selected DUT reports DONE.
    task automatic run_vec(input vec_t v, input string tag);
        int   n;
        logic got;
        vec_t e;
        sb.push_back(v);
        num_used = 7'(v.used);
        num_inst = '0; out_port = '0; halt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            num_inst = 32'(n);
            out_port = ans_of(n, v.bad_at);
            halt = n == v.halt_at;
            tick();
            got = v.sel ? if1.DONE : if0.DONE;
            n += v.inc;
            if (n == v.skip_at) n += v.inc;
        end
        halt = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s.timeout: DONE never rose within 40 cycles", tag);
        end else check_outs(e.sel, tag, e);
        halt = 1'b1;
        tick();
        halt = 1'b0; num_inst = '0; out_port = '0;
        tick();
    endtask

    task automatic load(input int idx, input int ni, input int an);
        tbl_we = 1'b1; tbl_idx = 6'(idx); tbl_ninst = 32'(ni); tbl_ans = 32'(an);
        tick();
        tbl_we = 1'b0;
    endtask

    initial begin
        //           sel used inc halt skip bad | pass code idx val  pc fc cyc
        vecs[0] = '{0, 3, 1, 10, -1, -1, 1, 0, 0, 0,    3, 0, 11};
        vecs[1] = '{1, 3, 1, 10, -1, -1, 1, 0, 0, 0,    3, 0, 11};
        vecs[2] = '{0, 3, 1, 10, -1,  6, 0, 1, 1, 'h19, 1, 1, 7};
        vecs[3] = '{1, 3, 1, 10,  6, -1, 0, 2, 1, 0,    2, 1, 10};
        vecs[4] = '{0, 3, 1,  6, -1, -1, 0, 2, 2, 'h18, 2, 1, 7};
        vecs[5] = '{1, 3, 0, -1, -1, -1, 1, 3, 0, 0,    0, 0, 20};
        vecs[6] = '{1, 3, 1, 10, -1,  6, 0, 1, 1, 'h19, 2, 1, 11};
        vecs[7] = '{0, 0, 1,  2, -1, -1, 1, 0, 0, 0,    0, 0, 3};
        vecs[8] = '{1, 2, 1, 10, -1, -1, 1, 0, 0, 0,    2, 0, 11};
        rstn = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_ninst = '0; tbl_ans = '0;
        num_used = '0; start = 1'b0; num_inst = '0; out_port = '0; halt = 1'b0;
        tick(); tick();
        chk("rst.done", 32'(if0.DONE), 32'd0);
        chk("rst.pass", 32'(if0.PASS), 32'd0);
        chk("rst.code", 32'(if0.FAIL_CODE), 32'd0);
        chk("rst.pcnt", 32'(if1.PASS_CNT), 32'd0);
        chk("rst.cycle", if1.CYCLE, 32'd0);
        rstn = 1'b1;
        tick();
        load(0, 4, 'h0F00);
        load(1, 6, 'h18);
        load(2, 8, 'h1D);
        for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));
        // TBL_WE while running must not corrupt the table
        num_used = 7'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tbl_we = 1'b1; tbl_idx = 6'd1; tbl_ninst = 32'd6; tbl_ans = 32'h77; halt = 1'b1;
        tick();
        tbl_we = 1'b0; halt = 1'b0;
        chk("werun.done", 32'(if0.DONE), 32'd1);
        tick();
        run_vec(vecs[0], "rerun");
        // reset in the middle of a run
        num_used = 7'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            num_inst = 32'(n); out_port = ans_of(n, -1);
            tick();
        end
        chk("mid.pcnt", 32'(if0.PASS_CNT), 32'd1);
        rstn = 1'b0;
        tick();
        chk("mid.rst.pcnt", 32'(if0.PASS_CNT), 32'd0);
        chk("mid.rst.cycle", if0.CYCLE, 32'd0);
        chk("mid.rst.done", 32'(if1.DONE), 32'd0);
        rstn = 1'b1; num_inst = '0; out_port = '0;
        tick();
        // START with TBL_WE in IDLE: the write lands before the run uses it
        tbl_we = 1'b1; tbl_idx = 6'd2; tbl_ninst = 32'd8; tbl_ans = 32'h55;
        run_vec('{1, 3, 1, 10, -1, -1, 0, 1, 2, 'h1D, 2, 1, 11}, "startwe");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    always @(posedge clk) if (start) tbl_we <= 1'b0;
endmodule
